// File: rtl/ste_stream_controller_pkg.sv
// ste_ctrl_pkg: state encoding, report entry and default widths shared by the STE stream controller files.
package ste_ctrl_pkg;
  localparam int CHAR_W_DEF = 16;
  localparam int OFFSET_W_DEF = 24;
  localparam int FIFO_DEPTH_DEF = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_e;
  typedef struct packed {
    logic [OFFSET_W_DEF-1:0] offset;
  } rpt_entry_t;
endpackage

// File: rtl/ste_stream_controller_if.sv
// ste_stream_controller_if: stream, STE network and report signals; STE_REPORT_COUNT_EN adds rpt_total.
interface ste_stream_controller_if
  import ste_ctrl_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF
);
  logic start;
  logic in_valid;
  logic [CHAR_W-1:0] in_data;
  logic in_last;
  logic in_ready;
  logic [CHAR_W-1:0] ste_char;
  logic ste_enable;
  logic ste_clear;
  logic ste_result;
  logic rpt_valid;
  logic [OFFSET_W-1:0] rpt_offset;
  logic rpt_ready;
  logic busy;
  logic done;
`ifdef STE_REPORT_COUNT_EN
  logic [31:0] rpt_total;
`endif
  modport master (
    input start, in_valid, in_data, in_last, ste_result, rpt_ready,
    output in_ready, ste_char, ste_enable, ste_clear, rpt_valid, rpt_offset, busy, done
`ifdef STE_REPORT_COUNT_EN
    , output rpt_total
`endif
  );
  modport slave (
    output start, in_valid, in_data, in_last, ste_result, rpt_ready,
    input in_ready, ste_char, ste_enable, ste_clear, rpt_valid, rpt_offset, busy, done
`ifdef STE_REPORT_COUNT_EN
    , input rpt_total
`endif
  );
endinterface

// File: rtl/ste_stream_controller_report_fifo.sv
// ste_report_fifo: synchronous report FIFO; contents become invisible on async reset via the counters.
module ste_report_fifo
  import ste_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter type entry_t = rpt_entry_t
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push_i,
  input  entry_t data_i,
  input  logic pop_i,
  output entry_t head_o,
  output logic empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  always_ff @(posedge clock)
    if (push_i) mem_q[wr_q] <= data_i;
  assign head_o = mem_q[rd_q];
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/ste_stream_controller.sv
// ste_stream_controller: feeds one character per step to the STE network and queues its reports with offsets.
// Define STE_REPORT_COUNT_EN to add the saturating rpt_total report counter.
module ste_stream_controller
  import ste_ctrl_pkg::*;
#(
  parameter int CHAR_W = CHAR_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic clock,
  input logic reset_n,
  ste_stream_controller_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef struct packed {
    logic [OFFSET_W-1:0] offset;
  } entry_t;
  state_e state_q, state_d;
  logic [OFFSET_W-1:0] off_q, off_d, stage_off_q;
  logic [CHAR_W-1:0] char_q;
  logic stage_v_q, ready, accept, push, pop, empty;
  logic [CW-1:0] count;
  entry_t head, push_entry;
  // the staged character counts as an occupied slot, so its report always has room
  assign ready = state_q == RUN && (count + CW'(stage_v_q)) < CW'(FIFO_DEPTH);
  assign accept = bus.in_valid && ready;
  assign push = stage_v_q && bus.ste_result;
  assign pop = bus.rpt_ready && !empty;
  assign off_d = state_q == CLEAR ? '0 : accept ? off_q + OFFSET_W'(1) : off_q;
  assign push_entry.offset = stage_off_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = bus.start ? CLEAR : IDLE;
      CLEAR: state_d = RUN;
      RUN:   state_d = accept && bus.in_last ? DRAIN : RUN;
      DRAIN: state_d = !stage_v_q && empty ? DONE : DRAIN;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      off_q <= '0;
      stage_off_q <= '0;
      stage_v_q <= 1'b0;
      char_q <= '0;
    end else begin
      state_q <= state_d;
      off_q <= off_d;
      stage_v_q <= accept;
      if (accept) begin
        char_q <= bus.in_data;
        stage_off_q <= off_q;
      end
    end
  ste_report_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
    .clock(clock),
    .reset_n(reset_n),
    .push_i(push),
    .data_i(push_entry),
    .pop_i(pop),
    .head_o(head),
    .empty_o(empty),
    .count_o(count)
  );
  assign bus.in_ready = ready;
  assign bus.ste_char = char_q;
  assign bus.ste_enable = stage_v_q;
  assign bus.ste_clear = state_q == CLEAR;
  assign bus.rpt_valid = !empty;
  assign bus.rpt_offset = head.offset;
  assign bus.busy = state_q != IDLE;
  assign bus.done = state_q == DONE;
`ifdef STE_REPORT_COUNT_EN
  logic [31:0] total_q;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) total_q <= '0;
    else if (state_q == CLEAR) total_q <= '0;
    else if (push && !(&total_q)) total_q <= total_q + 32'd1;
  assign bus.rpt_total = total_q;
`endif
endmodule
